fifo_stream_reader: RTL

- Downstream consumer of the synchronous FIFO.
- Drains the FIFO's read port (w_en/r_en style, 1-cycle registered read data) and presents the words as a valid/ready stream with packet framing (m_last every PKT_LEN beats).
- Holds a 3-entry output buffer so full throughput is sustained with no combinational path from m_ready to fifo r_en.
- Sits between the FIFO and any stream sink.

---
 rtl/fifo_stream_pkg.sv | 19 +
 rtl/stream_out_buf.sv | 72 +++++++
 rtl/fifo_stream_reader.sv | 74 +++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO stream reader: buffer depth, occupancy
// encoding and the sizing helper for the packet beat index.
package fifo_stream_pkg;

   localparam int BUF_DEPTH = 3;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2,
      FULL  = 2'd3
   } occ_state_t;

   // A one-beat packet still needs a 1-bit index so the compare logic stays uniform.
   function automatic int beat_idx_width(input int pkt_len);
      return (pkt_len <= 1) ? 1 : $clog2(pkt_len);
   endfunction

endpackage

// File: rtl/stream_out_buf.sv
// Three-entry circular output buffer: push at tail, pop at head,
// occupancy tracked as an explicit EMPTY/ONE/TWO/FULL state.
module stream_out_buf
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output occ_state_t            occ,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [1:0]            head_ptr;
   logic [1:0]            tail_ptr;
   occ_state_t            occ_next;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   // Push and pop together leave occupancy unchanged; only the pointers move.
   always_comb begin
      occ_next = occ;
      unique case ({push, pop})
         2'b10: begin
            unique case (occ)
               EMPTY:   occ_next = ONE;
               ONE:     occ_next = TWO;
               TWO:     occ_next = FULL;
               default: occ_next = FULL;
            endcase
         end
         2'b01: begin
            unique case (occ)
               FULL:    occ_next = TWO;
               TWO:     occ_next = ONE;
               ONE:     occ_next = EMPTY;
               default: occ_next = EMPTY;
            endcase
         end
         default: occ_next = occ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
         head_ptr <= 2'd0;
         tail_ptr <= 2'd0;
         occ      <= EMPTY;
      end else begin
         if (push) begin
            mem[tail_ptr] <= push_data;
            tail_ptr      <= ptr_inc(tail_ptr);
         end
         if (pop) begin
            head_ptr <= ptr_inc(head_ptr);
         end
         occ <= occ_next;
      end
   end

   assign head_data = mem[head_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO read port into a valid/ready stream with packet
// framing; reads are issued only against free buffer slots, never from m_ready.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_r_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  beat_cnt_total
);

   localparam int                BEAT_W   = beat_idx_width(PKT_LEN);
   localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(PKT_LEN - 1);

   logic              running;
   logic              inflight;
   logic              pop;
   logic [2:0]        pending;
   logic [BEAT_W-1:0] beat_idx;
   occ_state_t        occ;

   // Reserving a slot per in-flight read guarantees the capture never overflows.
   assign pending   = {1'b0, occ} + {2'b00, inflight};
   assign fifo_r_en = running && en && !fifo_empty && (pending < 3'(BUF_DEPTH));

   assign m_valid = (occ != EMPTY);
   assign pop     = m_valid && m_ready;
   assign m_last  = (beat_idx == LAST_IDX);

   // running holds reads off until the first edge after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         running  <= 1'b0;
         inflight <= 1'b0;
      end else begin
         running  <= 1'b1;
         inflight <= fifo_r_en;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_idx       <= '0;
         beat_cnt_total <= '0;
      end else if (pop) begin
         beat_idx       <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
         beat_cnt_total <= beat_cnt_total + 1'b1;
      end
   end

   stream_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (fifo_data_out),
      .pop       (pop),
      .occ       (occ),
      .head_data (m_data)
   );

endmodule
